// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PAUSE} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [INSTR_W-1:0] inst;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: small synchronous FIFO of fetch packets; flush overrides push.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_pkt_t    din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_pkt_t    head
);
  fetch_pkt_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign head = mem_q[rp_q];
  assign do_push = push & ~flush;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle SRAM reads into a fetch buffer with redirect flush.
// Define FETCH_PERF_CNT_EN to enable the perf_fetched/perf_bubbles counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int IMEM_AW = 10,
  parameter int BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_ren,
  output logic [IMEM_AW-1:0] imem_raddr,
  input  logic [31:0]        imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t state_q;
  logic [31:0] pc_q, pc_d, tag_q, tgt;
  logic inflight_q, redir, issue, deq, full, empty;
  logic [CW-1:0] count, occ;
  fetch_pkt_t head;
  assign tgt = redirect_pc & ~32'd3;
  assign redir = redirect_valid & (state_q != S_BOOT);
  assign deq = inst_valid & inst_ready;
  // Slots already committed: buffered + returning next edge, minus what leaves now.
  assign occ = count + CW'(inflight_q) - CW'(deq);
  assign issue = (state_q == S_RUN) & (redir | ((occ < CW'(BUF_DEPTH)) & ~(full & ~deq)));
  assign imem_ren = issue;
  assign imem_raddr = redir ? tgt[IMEM_AW+1:2] : pc_q[IMEM_AW+1:2];
  assign inst_valid = ~empty;
  assign inst = inst_valid ? head.inst : '0;
  assign inst_pc = inst_valid ? head.pc : '0;
  always_comb pc_d = redir ? (state_q == S_RUN ? tgt + PC_INC : tgt) : issue ? pc_q + PC_INC : pc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= fetch_en ? S_RUN : S_PAUSE;
      pc_q <= pc_d;
      tag_q <= redir ? tgt : pc_q;
      inflight_q <= issue;
    end
  end
  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .pop(deq),
    .flush(redir),
    .din('{pc: tag_q, inst: imem_rdata}),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(deq);
      bubbles_q <= bubbles_q + 32'((state_q == S_RUN) & inst_ready & ~inst_valid);
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected PCs queued as stimulus is driven, checked on dequeue.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_ren, inst_valid;
  logic [9:0] imem_raddr;
  logic [31:0] inst, inst_pc, perf_fetched, perf_bubbles, mon_e, h;
  int checks = 0, failures = 0, n_deq = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_ren(imem_ren), .imem_raddr(imem_raddr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
  );

  // Instruction memory: word at address a holds 0x1000_0000 + a, one-cycle latency
  always @(posedge clk) if (imem_ren) imem_rdata <= 32'h1000_0000 + {22'b0, imem_raddr};

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      n_deq++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL deq_unexpected inst_pc=%h required=none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc !== mon_e || inst !== 32'h1000_0000 + {22'b0, mon_e[11:2]}) begin
          failures++;
          $display("FAIL deq_order inst_pc=%h inst=%h required pc=%h inst=%h",
                   inst_pc, inst, mon_e, 32'h1000_0000 + {22'b0, mon_e[11:2]});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input logic [31:0] s);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(s + 32'(4 * i));
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if (imem_ren !== 1'b0 || inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0) begin
      failures++;
      $display("FAIL reset_outputs ren=%b valid=%b inst=%h pc=%h required 0", imem_ren, inst_valid, inst, inst_pc);
    end
    checks++;
    if (perf_fetched !== '0 || perf_bubbles !== '0) begin
      failures++;
      $display("FAIL reset_perf fetched=%0d bubbles=%0d required 0", perf_fetched, perf_bubbles);
    end
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    stream(32'h0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_ren !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_no_issue ren=%b valid=%b required 0 0", imem_ren, inst_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_ren !== 1'b1 || imem_raddr !== 10'd0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_issue ren=%b raddr=%h valid=%b required 1 000 0", imem_ren, imem_raddr, inst_valid);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid=%b required 0", inst_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1) begin
        failures++;
        $display("FAIL steady_valid cycle=%0d valid=%b required 1", i, inst_valid);
      end
    end
  endtask

  task automatic test_stall;
    step(1);
    inst_ready = 1'b0;
    @(negedge clk);
    h = inst_pc;
    checks++;
    if (h !== exp_q[0]) begin
      failures++;
      $display("FAIL stall_head inst_pc=%h required=%h", h, exp_q[0]);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (inst_pc !== h || inst_valid !== 1'b1 || imem_ren !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d pc=%h valid=%b ren=%b required pc=%h 1 0", i, inst_pc, inst_valid, imem_ren, h);
      end
    end
    step(1);
    inst_ready = 1'b1;
    step(6);
  endtask

  task automatic test_redirect;
    step(1);
    inst_ready = 1'b0;
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    stream(32'h40);
    @(negedge clk);
    checks++;
    if (imem_ren !== 1'b1 || imem_raddr !== 10'h10) begin
      failures++;
      $display("FAIL redirect_issue ren=%b raddr=%h required 1 010", imem_ren, imem_raddr);
    end
    step(1);
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush valid=%b required 0", inst_valid);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
      failures++;
      $display("FAIL redirect_target valid=%b pc=%h required 1 00000040", inst_valid, inst_pc);
    end
    step(4);
  endtask

  task automatic test_back_to_back;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step(1);
    redirect_pc = 32'h100;
    stream(32'h100);
    @(negedge clk);
    checks++;
    if (imem_ren !== 1'b1 || imem_raddr !== 10'h40 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_issue ren=%b raddr=%h valid=%b required 1 040 0", imem_ren, imem_raddr, inst_valid);
    end
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_killed valid=%b pc=%h required 0", inst_valid, inst_pc);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      failures++;
      $display("FAIL b2b_target valid=%b pc=%h required 1 00000100", inst_valid, inst_pc);
    end
    step(5);
  endtask

  task automatic test_pause;
    step(1);
    fetch_en = 1'b0;
    step(6);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_ren !== 1'b0) begin
      failures++;
      $display("FAIL pause_drain valid=%b ren=%b required 0 0", inst_valid, imem_ren);
    end
    step(1);
    fetch_en = 1'b1;
    step(1);
    @(negedge clk);
    checks++;
    if (imem_ren !== 1'b1 || imem_raddr !== exp_q[0][11:2]) begin
      failures++;
      $display("FAIL pause_resume ren=%b raddr=%h required 1 %h", imem_ren, imem_raddr, exp_q[0][11:2]);
    end
    step(6);
  endtask

  task automatic test_async_reset;
    step(2);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_ren !== 1'b0 || inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0 ||
        perf_fetched !== '0 || perf_bubbles !== '0) begin
      failures++;
      $display("FAIL async_reset ren=%b valid=%b inst=%h pc=%h fetched=%0d bubbles=%0d required all 0",
               imem_ren, inst_valid, inst, inst_pc, perf_fetched, perf_bubbles);
    end
    @(posedge clk);
    #1;
    stream(32'h0);
    n_deq = 0;
    rst = 1'b0;
    for (int i = 0; i < 40 && n_deq < 10; i++) step(1);
    inst_ready = 1'b0;
    checks++;
    if (n_deq != 10) begin
      failures++;
      $display("FAIL restart_timeout dequeues=%0d required 10", n_deq);
    end
    @(negedge clk);
    checks++;
`ifdef FETCH_PERF_CNT_EN
    if (perf_fetched !== 32'd10 || perf_bubbles !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts fetched=%0d bubbles=%0d required 10 2", perf_fetched, perf_bubbles);
    end
`else
    if (perf_fetched !== '0 || perf_bubbles !== '0) begin
      failures++;
      $display("FAIL perf_tied fetched=%0d bubbles=%0d required 0 0", perf_fetched, perf_bubbles);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_pause();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
